vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Upstream raster-timing stage for the text-editor display. Divides the system clock
//  into a pixel tick and runs horizontal/vertical counters. Drives hsync/vsync to the
//  VGA connector. Supplies pixel_x/pixel_y/video_on/p_tick to text_screen_gen and the
//  final RGB mux.
// PARAMETERS
//  CLK_DIV    2    system clocks per pixel (>=1); 50 MHz / 2 = 25 MHz pixel clock
//  H_DISPLAY  640  visible pixels per line
//  H_FP       16   horizontal front porch (pixels)
//  H_SYNC     96   horizontal sync width (pixels)
//  H_BP       48   horizontal back porch (pixels)
//  V_DISPLAY  480  visible lines per frame
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vertical sync width (lines)
//  V_BP       33   vertical back porch (lines)
//  SYNC_POL   0    active level of hsync/vsync (0 = active-low)
// PORTS
//  clk          in   1   system clock; all state on rising edge
//  reset        in   1   asynchronous, active-high reset
//  p_tick       out  1   one-clk pulse, once every CLK_DIV clocks
//  pixel_x      out  10  current column, 0..H_TOTAL-1
//  pixel_y      out  10  current row, 0..V_TOTAL-1
//  video_on     out  1   1 when pixel_x<H_DISPLAY and pixel_y<V_DISPLAY
//  hsync        out  1   horizontal sync, registered
//  vsync        out  1   vertical sync, registered
//  frame_start  out  1   one-clk pulse when the counters wrap to (0,0)
// BEHAVIOUR
//  - H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
//    Both totals must be <= 1024; elaboration fails otherwise.
//  - Reset (async, any time, including mid-frame):
//    tick divider=0, pixel_x=0, pixel_y=0, p_tick=0, frame_start=0,
//    hsync=vsync=~SYNC_POL (inactive). The first p_tick follows CLK_DIV clocks after
//    reset deassertion.
//  - Divider: counts 0..CLK_DIV-1 and wraps. p_tick is registered and high in the
//    cycle the divider is at CLK_DIV-1. With CLK_DIV=1, p_tick is constantly 1 after
//    the first clock.
//  - Horizontal: on a clock where p_tick=1, pixel_x <= (pixel_x==H_TOTAL-1) ? 0 :
//    pixel_x+1. No change when p_tick=0. pixel_x/pixel_y hold for exactly CLK_DIV
//    clocks.
//  - Vertical: advances only on a p_tick where pixel_x==H_TOTAL-1.
//    pixel_y <= (pixel_y==V_TOTAL-1) ? 0 : pixel_y+1.
//    The h-wrap and v-wrap occurring in the same tick is the frame wrap.
//  - frame_start: registered one-clk pulse in the same cycle the counters become (0,0).
//  - Syncs are registered from the next-state counts, so they are cycle-aligned with
//    pixel_x/pixel_y (0 latency relative to counts):
//    hsync active iff H_DISPLAY+H_FP <= x_next <= H_DISPLAY+H_FP+H_SYNC-1 (656..751);
//    vsync active iff V_DISPLAY+V_FP <= y_next <= V_DISPLAY+V_FP+V_SYNC-1 (490..491).
//  - video_on: combinational from the registered counts; never high in porch or sync.
//  - Downstream font ROM is one clock late. Consumers sample pixel_x on p_tick; CLK_DIV>=2
//    guarantees the ROM data is valid within the pixel.
// STRUCTURE
//  - Package vga_timing_pkg holds the 640x480@60 constants (H_/V_ values, totals,
//    SYNC_POL) and the 10-bit coord width. Shared with text_screen_gen and the RGB mux.
//  - One sub-module, pixel_tick_div: CLK_DIV counter plus p_tick register.
//  - h/v counters, sync regs and frame_start live in the top level.
// TESTING
//  1. Assert reset 3 clks, release -> outputs at reset values; first p_tick at clk 2
//     (CLK_DIV=2); then period exactly 2.
//  2. Run one line -> pixel_x 0..799 then 0; hsync low exactly for x=656..751 (96 ticks);
//     video_on high for x=0..639 only.
//  3. At x=799 on y=10 -> next tick x=0, y=11; y unchanged on every other tick.
//  4. Full frame -> vsync low for y=490..491 only; at (799,524) the next tick gives
//     (0,0) with one frame_start pulse; count 525*800 ticks between frame_starts.
//  5. Pulse reset mid-frame at (700,300) with hsync active -> immediately x=y=0 and
//     hsync=vsync=1; timing restarts cleanly.
//  6. Rerun with CLK_DIV=1 and SYNC_POL=1 -> p_tick constant 1; syncs active-high
//     over the same windows.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and coordinate types for the display pipeline.
package vga_timing_pkg;

    localparam int unsigned COORD_W   = 10;

    localparam int unsigned CLK_DIV   = 2;
    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;
    localparam int unsigned H_TOTAL   = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam bit          SYNC_POL  = 1'b0;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } raster_pos_t;

    // True when c lies in [lo, lo+len-1]; len must be at least 1.
    function automatic logic in_window(input coord_t c, input int unsigned lo,
                                       input int unsigned len);
        return (c >= COORD_W'(lo)) && (c <= COORD_W'(lo + len - 1));
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the text generator and RGB mux.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic   p_tick;
    coord_t pixel_x;
    coord_t pixel_y;
    logic   video_on;
    logic   hsync;
    logic   vsync;
    logic   frame_start;

    modport master (
        output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
    );

    modport slave (
        input p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
    );

endinterface

// File: rtl/pixel_tick_div.sv
// System-clock divider producing a registered one-clock pixel tick every CLK_DIV clocks.
module pixel_tick_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("pixel_tick_div: CLK_DIV must be at least 1");
        end
    endgenerate

    logic [DIV_W-1:0] div_q;

    // Tick registered from the divider's terminal count, so the first tick lands CLK_DIV clocks after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            p_tick <= 1'b0;
        end else begin
            div_q  <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
            p_tick <= (div_q == DIV_LAST);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel tick, h/v counters, registered syncs and frame_start pulse.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV   = vga_timing_pkg::CLK_DIV,
    parameter int unsigned H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int unsigned H_FP      = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP      = vga_timing_pkg::H_BP,
    parameter int unsigned V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int unsigned V_FP      = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP      = vga_timing_pkg::V_BP,
    parameter bit          SYNC_POL  = vga_timing_pkg::SYNC_POL
) (
    input  logic               clk,
    input  logic               reset,
    vga_timing_gen_if.master   vga
);
    import vga_timing_pkg::*;

    localparam int unsigned H_COUNT = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_COUNT = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam coord_t      H_LAST  = COORD_W'(H_COUNT - 1);
    localparam coord_t      V_LAST  = COORD_W'(V_COUNT - 1);

    generate
        if ((H_COUNT > 1024) || (V_COUNT > 1024)) begin : g_bad_total
            $error("vga_timing_gen: line or frame total exceeds the 10-bit coordinate range");
        end
    endgenerate

    logic        p_tick;
    raster_pos_t pos_q;
    raster_pos_t pos_d;
    logic        h_wrap;
    logic        v_wrap;
    logic        hsync_q;
    logic        vsync_q;
    logic        frame_q;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    // Next raster position; only a pixel tick moves the counters.
    always_comb begin
        pos_d  = pos_q;
        h_wrap = (pos_q.x == H_LAST);
        v_wrap = (pos_q.y == V_LAST);
        if (p_tick) begin
            pos_d.x = h_wrap ? '0 : pos_q.x + COORD_W'(1);
            if (h_wrap) begin
                pos_d.y = v_wrap ? '0 : pos_q.y + COORD_W'(1);
            end
        end
    end

    // Syncs decode the next position so they change on the same edge as the counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q   <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            frame_q <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            hsync_q <= in_window(pos_d.x, H_DISPLAY + H_FP, H_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync_q <= in_window(pos_d.y, V_DISPLAY + V_FP, V_SYNC) ? SYNC_POL : ~SYNC_POL;
            frame_q <= p_tick & h_wrap & v_wrap;
        end
    end

    assign vga.p_tick      = p_tick;
    assign vga.pixel_x     = pos_q.x;
    assign vga.pixel_y     = pos_q.y;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.frame_start = frame_q;
    assign vga.video_on    = (pos_q.x < COORD_W'(H_DISPLAY)) && (pos_q.y < COORD_W'(V_DISPLAY));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a standard 640x480 instance plus two shrunken rasters for frame-level behaviour.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   hs;
        logic   vs;
        logic   von;
    } tick_t;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    logic rst2;
    always #5 clk = ~clk;

    vga_timing_gen_if b0 ();
    vga_timing_gen_if b1 ();
    vga_timing_gen_if b2 ();

    vga_timing_gen #(.CLK_DIV(2), .SYNC_POL(1'b0)) u0 (
        .clk(clk), .reset(rst0), .vga(b0)
    );
    vga_timing_gen #(.CLK_DIV(2), .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_DISPLAY(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)) u1 (
        .clk(clk), .reset(rst1), .vga(b1)
    );
    vga_timing_gen #(.CLK_DIV(1), .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_DISPLAY(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)) u2 (
        .clk(clk), .reset(rst2), .vga(b2)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int unsigned cyc = 0;
    tick_t q0[$];
    tick_t q1[$];
    tick_t q2[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    task automatic check_tick(input string name, input tick_t got, input tick_t exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b von=%b, expected x=%0d y=%0d hs=%b vs=%b von=%b",
                      name, got.x, got.y, got.hs, got.vs, got.von,
                      exp.x, exp.y, exp.hs, exp.vs, exp.von);
    endtask

    // Reference raster for tick index k after reset; window bounds are hand-computed per geometry.
    function automatic tick_t model(input int id, input int unsigned k);
        int unsigned ht, vt, hs_lo, hs_hi, vs_lo, vs_hi, hd, vd, x, y;
        bit pol;
        tick_t t;
        if (id == 0) begin
            ht = 800; vt = 525; hs_lo = 656; hs_hi = 751; vs_lo = 490; vs_hi = 491;
            hd = 640; vd = 480; pol = 1'b0;
        end else begin
            ht = 15; vt = 8; hs_lo = 10; hs_hi = 12; vs_lo = 5; vs_hi = 6;
            hd = 8; vd = 4; pol = (id == 2);
        end
        x = k % ht;
        y = (k / ht) % vt;
        t.x   = 10'(x);
        t.y   = 10'(y);
        t.hs  = (x >= hs_lo && x <= hs_hi) ? pol : ~pol;
        t.vs  = (y >= vs_lo && y <= vs_hi) ? pol : ~pol;
        t.von = (x < hd) && (y < vd);
        return t;
    endfunction

    function automatic tick_t got_tick(input int id);
        tick_t t;
        case (id)
            0:       t = '{x: b0.pixel_x, y: b0.pixel_y, hs: b0.hsync, vs: b0.vsync, von: b0.video_on};
            1:       t = '{x: b1.pixel_x, y: b1.pixel_y, hs: b1.hsync, vs: b1.vsync, von: b1.video_on};
            default: t = '{x: b2.pixel_x, y: b2.pixel_y, hs: b2.hsync, vs: b2.vsync, von: b2.video_on};
        endcase
        return t;
    endfunction

    function automatic int qsize(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Tuple monitors: every presented pixel is compared against the next expected entry.
    always @(negedge clk) if (!rst0 && b0.p_tick && q0.size() != 0) check_tick("d0_tick", got_tick(0), q0.pop_front());
    always @(negedge clk) if (!rst1 && b1.p_tick && q1.size() != 0) check_tick("d1_tick", got_tick(1), q1.pop_front());
    always @(negedge clk) if (!rst2 && b2.p_tick && q2.size() != 0) check_tick("d2_tick", got_tick(2), q2.pop_front());

    int unsigned last_tick0;
    bit          have_tick0;
    always @(negedge clk) begin
        if (rst0) have_tick0 <= 1'b0;
        else if (b0.p_tick) begin
            if (have_tick0) check("d0_tick_period", int'(cyc - last_tick0), 2);
            last_tick0 <= cyc;
            have_tick0 <= 1'b1;
        end
    end

    int unsigned last_fs1, last_fs2;
    int          fs_cnt1, fs_cnt2;
    bit          have_fs1, have_fs2;
    always @(negedge clk) begin
        if (rst1) begin
            have_fs1 <= 1'b0;
            fs_cnt1  <= 0;
        end else if (b1.frame_start) begin
            check("d1_fs_pos", int'({b1.pixel_x, b1.pixel_y}), 0);
            if (have_fs1) check("d1_fs_gap", int'(cyc - last_fs1), 15 * 8 * 2);
            last_fs1 <= cyc;
            have_fs1 <= 1'b1;
            fs_cnt1  <= fs_cnt1 + 1;
        end
    end
    always @(negedge clk) begin
        if (rst2) begin
            have_fs2 <= 1'b0;
            fs_cnt2  <= 0;
        end else if (b2.frame_start) begin
            check("d2_fs_pos", int'({b2.pixel_x, b2.pixel_y}), 0);
            if (have_fs2) check("d2_fs_gap", int'(cyc - last_fs2), 15 * 8);
            last_fs2 <= cyc;
            have_fs2 <= 1'b1;
            fs_cnt2  <= fs_cnt2 + 1;
        end
    end

    task automatic drain(input int id, input int budget, input string name);
        int n = 0;
        while (qsize(id) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, qsize(id), 0);
    endtask

    task automatic wait_pos(input int id, input int unsigned x, input int unsigned y,
                            input int budget, input string name);
        int n = 0;
        tick_t t;
        @(negedge clk);
        t = got_tick(id);
        while (!(t.x == 10'(x) && t.y == 10'(y)) && n < budget) begin
            @(negedge clk);
            t = got_tick(id);
            n++;
        end
        check(name, int'(n < budget), 1);
    endtask

    initial begin
        int n;
        int low;
        rst0 = 1'b1;
        rst1 = 1'b1;
        rst2 = 1'b1;
        repeat (3) @(negedge clk);

        // Standard raster: reset values, first tick latency, lines 0..10 plus the wrap into line 11.
        check("d0_rst_x", int'(b0.pixel_x), 0);
        check("d0_rst_y", int'(b0.pixel_y), 0);
        check("d0_rst_ptick", int'(b0.p_tick), 0);
        check("d0_rst_fs", int'(b0.frame_start), 0);
        check("d0_rst_hsync", int'(b0.hsync), 1);
        check("d0_rst_vsync", int'(b0.vsync), 1);
        check("d0_rst_von", int'(b0.video_on), 1);
        for (int k = 0; k < 8802; k++) q0.push_back(model(0, k));
        rst0 = 1'b0;
        @(posedge clk); #1 check("d0_ptick_clk1", int'(b0.p_tick), 0);
        @(posedge clk); #1 check("d0_ptick_clk2", int'(b0.p_tick), 1);
        @(posedge clk); #1 check("d0_ptick_clk3", int'(b0.p_tick), 0);
        wait_pos(0, 799, 10, 20000, "d0_reach_799_10");
        n = 0;
        while (b0.pixel_x == 10'd799 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("d0_hwrap_x", int'(b0.pixel_x), 0);
        check("d0_hwrap_y", int'(b0.pixel_y), 11);
        drain(0, 2000, "d0_drain");
        rst0 = 1'b1;

        // Small raster, CLK_DIV=2: two full frames, then a mid-frame reset during hsync.
        @(negedge clk);
        for (int k = 0; k < 250; k++) q1.push_back(model(1, k));
        rst1 = 1'b0;
        drain(1, 1000, "d1_drain_a");
        check("d1_fs_count_a", fs_cnt1, 2);
        wait_pos(1, 11, 2, 1000, "d1_reach_11_2");
        check("d1_hs_active", int'(b1.hsync), 0);
        q1.delete();
        #2 rst1 = 1'b1;
        #1;
        check("d1_mid_x", int'(b1.pixel_x), 0);
        check("d1_mid_y", int'(b1.pixel_y), 0);
        check("d1_mid_hsync", int'(b1.hsync), 1);
        check("d1_mid_vsync", int'(b1.vsync), 1);
        check("d1_mid_ptick", int'(b1.p_tick), 0);
        check("d1_mid_fs", int'(b1.frame_start), 0);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 130; k++) q1.push_back(model(1, k));
        rst1 = 1'b0;
        drain(1, 600, "d1_drain_b");
        check("d1_fs_count_b", fs_cnt1, 1);
        rst1 = 1'b1;

        // Small raster, CLK_DIV=1 with active-high syncs.
        @(negedge clk);
        check("d2_rst_hsync", int'(b2.hsync), 0);
        check("d2_rst_vsync", int'(b2.vsync), 0);
        for (int k = 0; k < 250; k++) q2.push_back(model(2, k));
        rst2 = 1'b0;
        @(posedge clk);
        low = 0;
        repeat (200) begin
            @(negedge clk);
            if (!b2.p_tick) low++;
        end
        check("d2_ptick_const", low, 0);
        drain(2, 200, "d2_drain");
        check("d2_fs_count", fs_cnt2, 2);
        rst2 = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
